// File: rtl/complement_arbiter.sv
// complement_arbiter: two requesters share one complement unit (pass / ones' / twos').
// Round-robin grant, valid/ready request handshake, one registered result stage with
// backpressure. Define COMPL_OVF_EN to add the res_ovf output (twos' complement of the
// most-negative operand).
module complement_arbiter #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [1:0]       req0_op,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [1:0]       req1_op,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             res_err,
    input  logic             res_ready
`ifdef COMPL_OVF_EN
    ,
    output logic             res_ovf
`endif
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e           state_q, state_d;
    logic             last_grant_q;
    logic [WIDTH-1:0] res_data_q;
    logic             res_id_q;
    logic             res_err_q;

    logic             grant;
    logic             can_accept;
    logic             accept;
    logic [WIDTH-1:0] sel_a;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] calc_data;
    logic             calc_err;

    // Round-robin grant; the requester that did not win last acceptance wins a tie.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Handshake: the result register can take a new value when empty or being drained.
    always_comb begin
        can_accept = !rst && ((state_q == StEmpty) || res_ready);
        req0_ready = can_accept && req0_valid && (grant == 1'b0);
        req1_ready = can_accept && req1_valid && (grant == 1'b1);
        accept     = req0_ready || req1_ready;
    end

    // Shared complement unit fed by the granted requester.
    always_comb begin
        sel_a     = grant ? req1_a  : req0_a;
        sel_op    = grant ? req1_op : req0_op;
        calc_data = '0;
        calc_err  = 1'b0;
        unique case (sel_op)
            2'd0: calc_data = sel_a;
            2'd1: calc_data = ~sel_a;
            2'd2: calc_data = ~sel_a + WIDTH'(1);
            2'd3: calc_err  = 1'b1;
            default: ;
        endcase
    end

    // Result-register FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (accept) state_d = StFull;
            StFull:  if (res_ready && !accept) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    // State, priority pointer and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StEmpty;
            last_grant_q <= 1'b1;
            res_data_q   <= '0;
            res_id_q     <= 1'b0;
            res_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_grant_q <= grant;
                res_data_q   <= calc_data;
                res_id_q     <= grant;
                res_err_q    <= calc_err;
            end
        end
    end

`ifdef COMPL_OVF_EN
    logic res_ovf_q;
    logic calc_ovf;

    // Overflow: negating the most-negative value yields itself.
    always_comb begin
        calc_ovf = (sel_op == 2'd2) && (sel_a == {1'b1, {(WIDTH-1){1'b0}}});
    end

    // Overflow flag travels with the result data.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_ovf_q <= 1'b0;
        end else if (accept) begin
            res_ovf_q <= calc_ovf;
        end
    end

    assign res_ovf = res_ovf_q;
`endif

    assign res_valid = (state_q == StFull);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_complement_arbiter.sv
// Bench for complement_arbiter: table of per-cycle stimulus with expected readies,
// expected results queued on acceptance and compared when the consumer takes them.
module tb_complement_arbiter;

    localparam int unsigned WIDTH = 5;

    logic             clk;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic [WIDTH-1:0] req0_a, req1_a;
    logic [1:0]       req0_op, req1_op;
    logic             req0_ready, req1_ready;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             res_id;
    logic             res_err;
    logic             res_ready;
`ifdef COMPL_OVF_EN
    logic             res_ovf;
`endif

    complement_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_op    (req0_op),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_op    (req1_op),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_err    (res_err),
        .res_ready  (res_ready)
`ifdef COMPL_OVF_EN
        ,
        .res_ovf    (res_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic             v0;
        logic [WIDTH-1:0] a0;
        logic [1:0]       op0;
        logic             v1;
        logic [WIDTH-1:0] a1;
        logic [1:0]       op1;
        logic             rr;
        logic             er0;
        logic             er1;
    } stim_t;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             id;
        logic             err;
        logic             ovf;
    } res_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t sb[$];
    logic exp_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [1:0] op,
                                   input logic id);
        res_t r;
        r.id   = id;
        r.err  = (op == 2'd3);
        r.ovf  = (op == 2'd2) && (a == 5'b10000);
        case (op)
            2'd0:    r.data = a;
            2'd1:    r.data = ~a;
            2'd2:    r.data = WIDTH'(32'(~a) + 1);
            default: r.data = '0;
        endcase
        return r;
    endfunction

    function automatic stim_t mk(input logic r, input logic v0, input logic [4:0] a0,
                                 input logic [1:0] op0, input logic v1, input logic [4:0] a1,
                                 input logic [1:0] op1, input logic rr, input logic er0,
                                 input logic er1);
        stim_t s;
        s.rst = r;  s.v0 = v0; s.a0 = a0; s.op0 = op0;
        s.v1 = v1;  s.a1 = a1; s.op1 = op1; s.rr = rr;
        s.er0 = er0; s.er1 = er1;
        return s;
    endfunction

    // Drive one cycle, check readies and valid at negedge, score the consumed result.
    task automatic step(input stim_t s);
        res_t e;
        rst        = s.rst;
        req0_valid = s.v0; req0_a = s.a0; req0_op = s.op0;
        req1_valid = s.v1; req1_a = s.a1; req1_op = s.op1;
        res_ready  = s.rr;
        @(negedge clk);
        chk("req0_ready", 32'(req0_ready), 32'(s.er0));
        chk("req1_ready", 32'(req1_ready), 32'(s.er1));
        chk("res_valid", 32'(res_valid), 32'(exp_valid));
        if (exp_valid && s.rr && !s.rst) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard: result consumed with nothing expected");
            end else begin
                e = sb.pop_front();
                chk("res_data", 32'(res_data), 32'(e.data));
                chk("res_id", 32'(res_id), 32'(e.id));
                chk("res_err", 32'(res_err), 32'(e.err));
`ifdef COMPL_OVF_EN
                chk("res_ovf", 32'(res_ovf), 32'(e.ovf));
`endif
            end
        end
        if (s.rst) begin
            sb.delete();
            exp_valid = 1'b0;
        end else begin
            if (s.er0) sb.push_back(model(s.a0, s.op0, 1'b0));
            if (s.er1) sb.push_back(model(s.a1, s.op1, 1'b1));
            exp_valid = s.er0 || s.er1 || (exp_valid && !s.rr);
        end
        @(posedge clk);
        #1;
    endtask

    stim_t vec[$];

    initial begin
        logic [WIDTH-1:0] held;
        exp_valid = 1'b0;
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_op = '0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset held with both requesters valid, then main table.
        vec.push_back(mk(1, 1, 5'b00001, 2'd0, 1, 5'b00010, 2'd0, 1, 0, 0));
        vec.push_back(mk(1, 1, 5'b00001, 2'd0, 1, 5'b00010, 2'd0, 1, 0, 0));
        vec.push_back(mk(0, 1, 5'b00011, 2'd2, 1, 5'b00111, 2'd0, 1, 1, 0));
        vec.push_back(mk(0, 1, 5'b00011, 2'd2, 0, 5'b00000, 2'd0, 1, 1, 0));
        vec.push_back(mk(0, 1, 5'b01001, 2'd1, 1, 5'b00110, 2'd2, 1, 0, 1));
        vec.push_back(mk(0, 1, 5'b01010, 2'd0, 1, 5'b11111, 2'd1, 1, 1, 0));
        vec.push_back(mk(0, 1, 5'b01100, 2'd2, 1, 5'b00001, 2'd2, 1, 0, 1));
        vec.push_back(mk(0, 1, 5'b10001, 2'd1, 1, 5'b01111, 2'd0, 1, 1, 0));
        vec.push_back(mk(0, 0, 5'b00000, 2'd0, 0, 5'b00000, 2'd0, 1, 0, 0));
        vec.push_back(mk(0, 0, 5'b00000, 2'd0, 1, 5'b10101, 2'd3, 1, 0, 1));
        vec.push_back(mk(0, 0, 5'b00000, 2'd0, 1, 5'b10101, 2'd1, 1, 0, 1));
        vec.push_back(mk(0, 1, 5'b01110, 2'd0, 0, 5'b00000, 2'd0, 1, 1, 0));
        vec.push_back(mk(0, 1, 5'b00000, 2'd2, 1, 5'b10000, 2'd2, 1, 0, 1));
        vec.push_back(mk(0, 1, 5'b00000, 2'd2, 1, 5'b10000, 2'd2, 1, 1, 0));
        vec.push_back(mk(0, 0, 5'b00000, 2'd0, 0, 5'b00000, 2'd0, 1, 0, 0));
        vec.push_back(mk(0, 0, 5'b00000, 2'd0, 0, 5'b00000, 2'd0, 1, 0, 0));
        for (int i = 0; i < vec.size(); i++) step(vec[i]);

        // Spot check: twos' complement of 00011 is 11101 (literal, independent of model).
        step(mk(0, 1, 5'b00011, 2'd2, 0, 5'b00000, 2'd0, 1, 1, 0));
        chk("twos_00011", 32'(res_data), 32'(5'b11101));
        step(mk(0, 0, 5'b00000, 2'd0, 0, 5'b00000, 2'd0, 1, 0, 0));

        // Backpressure: result must hold for three stalled cycles, then drain and accept.
        step(mk(0, 1, 5'b00101, 2'd1, 0, 5'b00000, 2'd0, 1, 1, 0));
        held = res_data;
        chk("bp_first", 32'(held), 32'(5'b11010));
        for (int i = 0; i < 3; i++) begin
            step(mk(0, 1, 5'b00110, 2'd0, 1, 5'b01000, 2'd1, 0, 0, 0));
            chk("bp_hold", 32'(res_data), 32'(held));
        end
        step(mk(0, 1, 5'b00110, 2'd0, 1, 5'b01000, 2'd1, 1, 0, 1));
        chk("bp_next", 32'(res_data), 32'(5'b10111));
        step(mk(0, 0, 5'b00000, 2'd0, 0, 5'b00000, 2'd0, 1, 0, 0));

        // Reset while FULL discards the held result.
        step(mk(0, 1, 5'b01011, 2'd0, 0, 5'b00000, 2'd0, 0, 1, 0));
        step(mk(1, 1, 5'b01011, 2'd0, 1, 5'b00001, 2'd0, 0, 0, 0));
        step(mk(0, 0, 5'b00000, 2'd0, 0, 5'b00000, 2'd0, 1, 0, 0));
        chk("rst_full_data", 32'(res_data), 32'(0));

        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
